// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: issues one dbus transaction per op, formats load data,
// flags misalignment and holds the result until the pipeline accepts it.
module mem_access_ctrl #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            is_store,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   input  logic [1:0]      msize,
   input  logic            mem_unsigned,
   input  logic            flush,
   output logic            dreq_valid,
   output logic [XLEN-1:0] dreq_addr,
   output logic [1:0]      dreq_size,
   output logic [7:0]      dreq_strobe,
   output logic [XLEN-1:0] dreq_data,
   input  logic            dresp_data_ok,
   input  logic [XLEN-1:0] dresp_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] rdata,
   output logic            misalign,
   input  logic            accept
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} msize_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic [1:0]      size_q;
   logic [7:0]      strobe_q;
   logic            store_q, uns_q, misalign_q, killed_q;

   logic [7:0]      base;
   logic            mis_in;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] fmt;

   always_comb begin
      base   = 8'h01;
      mis_in = 1'b0;
      case (msize_t'(msize))
         MSIZE1: begin base = 8'h01; mis_in = 1'b0;          end
         MSIZE2: begin base = 8'h03; mis_in = addr[0];       end
         MSIZE4: begin base = 8'h0F; mis_in = |addr[1:0];    end
         MSIZE8: begin base = 8'hFF; mis_in = |addr[2:0];    end
         default: ;
      endcase
   end

   // Load field is right-aligned first, then extended from its own MSB.
   always_comb begin
      shifted = dresp_data >> {addr_q[2:0], 3'b000};
      fmt     = shifted;
      case (msize_t'(size_q))
         MSIZE1: fmt = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
         MSIZE2: fmt = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
         MSIZE4: fmt = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
         MSIZE8: fmt = dresp_data;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            busy = start & ~flush;
            if (start && !flush) state_d = mis_in ? DONE : BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (dresp_data_ok) state_d = (killed_q || flush) ? IDLE : DONE;
         end
         DONE: begin
            busy = ~accept;
            if (accept || flush) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         size_q     <= '0;
         strobe_q   <= '0;
         store_q    <= 1'b0;
         uns_q      <= 1'b0;
         misalign_q <= 1'b0;
         killed_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start && !flush) begin
                  addr_q     <= addr;
                  size_q     <= msize;
                  store_q    <= is_store;
                  uns_q      <= mem_unsigned;
                  wdata_q    <= is_store ? (wdata << {addr[2:0], 3'b000}) : '0;
                  strobe_q   <= is_store ? (base << addr[2:0]) : '0;
                  misalign_q <= mis_in;
                  rdata_q    <= '0;
                  killed_q   <= 1'b0;
               end
            end
            BUSY: begin
               // A flush cannot abort the bus cycle; remember it so the result is dropped.
               if (flush) killed_q <= 1'b1;
               if (dresp_data_ok) begin
                  killed_q <= 1'b0;
                  if (!store_q) rdata_q <= fmt;
               end
            end
            DONE: begin
               if (accept || flush) misalign_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign dreq_valid  = (state_q == BUSY);
   assign done        = (state_q == DONE);
   assign dreq_addr   = addr_q;
   assign dreq_size   = size_q;
   assign dreq_strobe = strobe_q;
   assign dreq_data   = wdata_q;
   assign rdata       = rdata_q;
   assign misalign    = misalign_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage controller that sequences one load or store per operation over the data bus (dbus).
- Sits between the EX/MEM pipeline register and the dbus port.
- Handles request/handshake sequencing, misalignment detection, byte-strobe and write-lane generation, and load-data lane extraction with sign/zero extension.
- Holds the result until the pipeline accepts it, and drives the memory-stage stall.

Parameters:
- XLEN, 64, data/address width in bits; only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  valid memory op presented by the EX/MEM register
- is_store  in  1  1 = store, 0 = load; sampled with start
- addr  in  64  byte address
- wdata  in  64  store data, right-aligned
- msize  in  2  msize_t: MSIZE1/2/4/8
- mem_unsigned  in  1  zero-extend the load when set
- flush  in  1  kill the current/next op
- dreq_valid  out  1  dbus request valid
- dreq_addr  out  64  request address, latched addr
- dreq_size  out  2  latched msize
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  64  lane-shifted store data
- dresp_data_ok  in  1  dbus transaction complete
- dresp_data  in  64  raw 64-bit read word
- busy  out  1  stall request to the pipeline
- done  out  1  result valid
- rdata  out  64  formatted load result
- misalign  out  1  exception flag, valid with done
- accept  in  1  pipeline consumes the result

Behaviour:
- Reset (async):
  - state = IDLE.
  - All outputs are 0: dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, busy, done, rdata, misalign.
  - killed = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and flush=0: latch addr, msize, is_store, mem_unsigned and the shifted wdata.
  - Misaligned op: go to DONE with misalign=1. No bus request is issued.
  - Aligned op: go to BUSY.
  - start=1 and flush=1: the op is ignored.
  - busy = start & ~flush, asserted combinationally in the same cycle.
- Misalignment rules:
  - MSIZE2: addr[0] != 0
  - MSIZE4: addr[1:0] != 0
  - MSIZE8: addr[2:0] != 0
  - MSIZE1: never misaligned
- BUSY:
  - dreq_valid=1, with all dreq_* fields held stable until dresp_data_ok=1 (inclusive).
  - On data_ok:
    - Loads capture the formatted rdata.
    - Go to DONE, or to IDLE if killed.
  - busy=1 throughout.
- flush while in BUSY:
  - The bus transaction is not abandoned; set killed=1.
  - On data_ok go to IDLE with no done pulse; killed clears.
- DONE:
  - done=1; rdata and misalign are held.
  - busy = ~accept.
  - accept=1: go to IDLE and clear done/misalign the next cycle.
  - flush=1 in DONE: go to IDLE, done drops, no exception is reported.
  - A start arriving in the same cycle as accept is not taken; it is sampled next cycle in IDLE.
- Store lanes, with o = addr[2:0]:
  - dreq_strobe = base << o, where base = 8'h01 / 8'h03 / 8'h0F / 8'hFF for MSIZE1/2/4/8.
  - dreq_data = wdata << (8*o).
  - For loads, dreq_strobe = 0 and dreq_data = 0.
- Load formatting:
  - Take the field of width 8/16/32/64 starting at bit 8*o of dresp_data.
  - Extend to 64 bits: zero-extend if mem_unsigned, else sign-extend from the field MSB.
  - MSIZE8 passes the word through unchanged.
  - All eight byte offsets are valid for MSIZE1, including o=2.
- Latency:
  - An aligned op with data_ok in the first BUSY cycle has done=1 two cycles after start.
  - Each extra wait cycle adds one cycle.
- dreq_valid is never asserted outside BUSY.
- done and dreq_valid are never asserted together.

Test Plan:
- LB sign: addr=0x1002, msize=MSIZE1, mem_unsigned=0, dresp_data=0x0000_0000_0080_0000, data_ok after 1 wait cycle -> rdata=0xFFFF_FFFF_FFFF_FF80, done on cycle 3, dreq_strobe=0.
- LHU/LW: addr=0x6, msize=MSIZE2, unsigned, dresp_data=0xBEEF_0000_0000_0000 -> rdata=0x000_0000_0000_BEEF. Then addr=0x4, MSIZE4, signed, dresp_data=0x8000_0001_0000_0000 -> rdata=0xFFFF_FFFF_8000_0001.
- Store SH: addr=0x3, MSIZE2 -> misalign=1 and done, dreq_valid never asserted. Then addr=0x2, wdata=0x1234 -> dreq_strobe=8'h0C, dreq_data=0x0000_0000_1234_0000.
- Handshake stall: data_ok held low 5 cycles -> dreq_valid and fields stable, busy=1 for all 5 cycles. Hold accept=0 for 3 cycles in DONE -> done/rdata stable, busy=1.
- Flush in BUSY: flush pulsed on the 2nd BUSY cycle, data_ok 2 cycles later -> no done pulse, IDLE after data_ok, busy drops.
- Reset mid-op: assert reset during BUSY -> dreq_valid, busy and done are 0 immediately (asynchronous), state IDLE. After reset release, a new LD at 0x8 completes normally.
